// File: rtl/block_serializer_if.sv
// block_serializer_if
// Bundles the block serializer's handshake and data signals.
//   master : producer/consumer side (drives start/request/abort/block)
//   slave  : serializer side (drives word/valid/last/index/busy/drop)
// Parameters WORD_W and NUM_WORDS must match the attached block_serializer.
interface block_serializer_if #(
   parameter int WORD_W    = 8,
   parameter int NUM_WORDS = 16
);
   localparam int IDX_W = $clog2(NUM_WORDS);

   logic                        start_in;
   logic                        request_in;
   logic                        abort_in;
   logic [NUM_WORDS*WORD_W-1:0] block_in;
   logic [WORD_W-1:0]           word_out;
   logic                        valid_out;
   logic                        last_out;
   logic [IDX_W-1:0]            index_out;
   logic                        busy_out;
   logic                        drop_out;

   modport master (
      output start_in, request_in, abort_in, block_in,
      input  word_out, valid_out, last_out, index_out, busy_out, drop_out
   );

   modport slave (
      input  start_in, request_in, abort_in, block_in,
      output word_out, valid_out, last_out, index_out, busy_out, drop_out
   );
endinterface

// File: rtl/block_serializer.sv
// block_serializer
// Captures a NUM_WORDS x WORD_W block in one cycle and hands it out one word
// per request cycle, with last/index flags, abort and selectable word order.
// Ports:
//   clk_in    : clock, rising edge
//   rst_n_in  : synchronous active-low reset
//   bus       : block_serializer_if.slave (start/request/abort/block in,
//               word/valid/last/index/busy/drop out)
// Optional build macro BLOCK_SERIALIZER_DOUBLE_BUFFER_EN adds a shadow block
// buffer so a following block can be queued during a stream and streamed with
// no bubble after the current block's final word.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | no block held; waiting for start_in, requests ignored
// S_STREAM | block held; each request cycle emits the word selected by count
module block_serializer #(
   parameter int WORD_W    = 8,
   parameter int NUM_WORDS = 16,
   parameter bit MSB_FIRST = 1'b0
) (
   input logic               clk_in,
   input logic               rst_n_in,
   block_serializer_if.slave bus
);
   localparam int CNT_W = $clog2(NUM_WORDS + 1);
   localparam int IDX_W = $clog2(NUM_WORDS);
   localparam int BLK_W = NUM_WORDS * WORD_W;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_WORDS - 1);

   typedef enum logic {S_IDLE, S_STREAM} state_t;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  count, count_nxt;
   logic [BLK_W-1:0]  main_buf, main_nxt;
   logic [WORD_W-1:0] word_q, word_nxt;
   logic [IDX_W-1:0]  index_q, index_nxt;
   logic              valid_q, valid_nxt;
   logic              last_q, last_nxt;
   logic              drop_q, drop_nxt;
   logic [CNT_W-1:0]  sel;
   logic [WORD_W-1:0] cur_word;
   logic              final_req;
   logic              pending;

`ifdef BLOCK_SERIALIZER_DOUBLE_BUFFER_EN
   logic [BLK_W-1:0]  shadow_buf, shadow_nxt;
   logic              pending_nxt;
`else
   assign pending = 1'b0;
`endif

   // count never reaches NUM_WORDS while streaming, so sel stays in range
   assign sel       = MSB_FIRST ? (LAST_CNT - count) : count;
   assign cur_word  = main_buf[int'(sel)*WORD_W +: WORD_W];
   assign final_req = bus.request_in && (count == LAST_CNT);

   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         state    <= S_IDLE;
         count    <= '0;
         main_buf <= '0;
         word_q   <= '0;
         index_q  <= '0;
         valid_q  <= 1'b0;
         last_q   <= 1'b0;
         drop_q   <= 1'b0;
      end else begin
         state    <= state_nxt;
         count    <= count_nxt;
         main_buf <= main_nxt;
         word_q   <= word_nxt;
         index_q  <= index_nxt;
         valid_q  <= valid_nxt;
         last_q   <= last_nxt;
         drop_q   <= drop_nxt;
      end
   end

`ifdef BLOCK_SERIALIZER_DOUBLE_BUFFER_EN
   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         shadow_buf <= '0;
         pending    <= 1'b0;
      end else begin
         shadow_buf <= shadow_nxt;
         pending    <= pending_nxt;
      end
   end
`endif

   always_comb begin
      state_nxt = state;
      count_nxt = count;
      main_nxt  = main_buf;
      word_nxt  = word_q;
      index_nxt = index_q;
      valid_nxt = 1'b0;
      last_nxt  = 1'b0;
      drop_nxt  = 1'b0;
`ifdef BLOCK_SERIALIZER_DOUBLE_BUFFER_EN
      shadow_nxt  = shadow_buf;
      pending_nxt = pending;
`endif
      unique case (state)
         S_IDLE: begin
            if (bus.start_in) begin
               main_nxt  = bus.block_in;
               count_nxt = '0;
               state_nxt = S_STREAM;
            end
         end
         S_STREAM: begin
            if (bus.abort_in) begin
               // abort beats both request and start
               state_nxt = S_IDLE;
               count_nxt = '0;
               drop_nxt  = bus.start_in;
`ifdef BLOCK_SERIALIZER_DOUBLE_BUFFER_EN
               pending_nxt = 1'b0;
`endif
            end else begin
               if (bus.request_in) begin
                  word_nxt  = cur_word;
                  index_nxt = count[IDX_W-1:0];
                  valid_nxt = 1'b1;
                  count_nxt = count + 1'b1;
               end
               if (final_req) begin
                  last_nxt  = 1'b1;
                  count_nxt = '0;
                  if (pending) begin
                     // queued block takes over; a start now has nowhere to go
`ifdef BLOCK_SERIALIZER_DOUBLE_BUFFER_EN
                     main_nxt    = shadow_buf;
                     pending_nxt = 1'b0;
`endif
                     drop_nxt = bus.start_in;
                  end else if (bus.start_in) begin
                     main_nxt = bus.block_in;
                  end else begin
                     state_nxt = S_IDLE;
                  end
               end else if (bus.start_in) begin
`ifdef BLOCK_SERIALIZER_DOUBLE_BUFFER_EN
                  if (!pending) begin
                     shadow_nxt  = bus.block_in;
                     pending_nxt = 1'b1;
                  end else begin
                     drop_nxt = 1'b1;
                  end
`else
                  drop_nxt = 1'b1;
`endif
               end
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign bus.word_out  = word_q;
   assign bus.index_out = index_q;
   assign bus.valid_out = valid_q;
   assign bus.last_out  = last_q;
   assign bus.drop_out  = drop_q;
   assign bus.busy_out  = (state == S_STREAM);
endmodule

// File: doc/block_serializer.md
Name: block_serializer

Overview:
- Parametrised successor to the fixed 16x8 block streamer.
- Captures a NUM_WORDS x WORD_W block in one cycle, then returns one word per request_in pulse, with last/index flags, abort and configurable word order.
- Sits between block-producing cores (e.g. cipher/hash rounds) and byte-wide consumers (UART/SPI/FIFO writers) that pull data at their own rate.

Parameters:
- WORD_W, 8, width of each output word in bits (>=1).
- NUM_WORDS, 16, words per block (>=2).
- MSB_FIRST, 0, 0: word 0 = block_in[WORD_W-1:0] goes first; 1: word NUM_WORDS-1 (top slice) goes first.

Ports:
- clk_in  input  1  system clock, all logic on rising edge.
- rst_n_in  input  1  synchronous active-low reset, sampled on clk_in rising edge.
- start_in  input  1  load block_in and begin a stream.
- request_in  input  1  consumer pulls one word (level; each high cycle is one request).
- abort_in  input  1  terminate current stream immediately.
- block_in  input  NUM_WORDS*WORD_W  flat block, word i = bits [i*WORD_W +: WORD_W].
- word_out  output  WORD_W  current output word, held between valids.
- valid_out  output  1  word_out valid, single-cycle per request.
- last_out  output  1  high with valid_out on final word of a block.
- index_out  output  $clog2(NUM_WORDS)  position (0..NUM_WORDS-1) of word_out in emission order.
- busy_out  output  1  high while in STREAM.
- drop_out  output  1  one-cycle pulse when a start_in is rejected.

Behaviour:
- Reset (rst_n_in=0 at edge): state IDLE, count=0. All outputs 0: word_out, valid_out, last_out, index_out, busy_out, drop_out. Shadow and pending cleared. Reset mid-stream discards the block, with no further valid.
- States: IDLE, STREAM.
- IDLE:
  - start_in=1 captures block_in into the main buffer, sets count=0 and moves to STREAM; busy_out=1 from the next cycle.
  - request_in is ignored in IDLE.
- STREAM:
  - Each cycle with request_in=1: word_out <= buffer word selected by count and MSB_FIRST, index_out <= count, valid_out <= 1, count <= count+1.
  - Latency is 1 cycle, request to valid.
  - Cycles without request_in: valid_out <= 0, last_out <= 0. word_out and index_out hold.
  - When count==NUM_WORDS-1 and request_in=1: last_out <= 1 with that word, then go to IDLE, or reload (see optional feature). There is no idle cycle between the final request and IDLE; busy_out drops the cycle after last_out's edge.
  - Back-to-back requests every cycle give NUM_WORDS consecutive valids.
- abort_in: in STREAM, abort_in=1 returns to IDLE with count=0 and pending cleared, and no valid that cycle. Abort beats request in the same cycle. In IDLE it has no effect.
- start_in in STREAM (base build): ignored, buffer untouched, drop_out=1 for one cycle.
- start_in in the same cycle as the final request (base build): treated as an IDLE start. The new block is captured into main, count=0, state stays STREAM, no drop.
- start_in with abort_in in the same cycle: abort wins, start is dropped (drop_out=1).
- Widths:
  - count is $clog2(NUM_WORDS+1) bits, compared against NUM_WORDS-1, never wraps.
  - Word select: MSB_FIRST=0 uses count; MSB_FIRST=1 uses NUM_WORDS-1-count.
  - index_out always reports emission order (count).

Optional Feature:
- Macro BLOCK_SERIALIZER_DOUBLE_BUFFER_EN.
- Defined:
  - Adds a shadow buffer and pending flag.
  - start_in in STREAM with pending=0 captures block_in into shadow and sets pending=1, no drop.
  - start_in in STREAM with pending=1 is dropped (drop_out pulse).
  - On the final request with pending=1: main <= shadow, pending <= 0, count <= 0, stay STREAM. The next request yields word 0 of the new block with no bubble.
  - Final request plus start_in with pending=0 loads main directly, as in the base build.
  - abort_in clears pending.
- Undefined: no shadow register, behaviour exactly as in Behaviour above.

Test Plan:
- Reset held 3 cycles then released, block_in=0x0F0E..0100, start, 16 consecutive requests -> valid_out on 16 consecutive cycles, words 0x00..0x0F, index 0..15, last_out only with 0x0F, busy_out low afterwards.
- MSB_FIRST=1, WORD_W=4, NUM_WORDS=4, block_in=0xABCD, requests every other cycle -> words D? No: emission order is 0xA,0xB,0xC,0xD. valid_out alternates 1/0, last_out with 0xD.
- Start, 5 requests, then abort_in together with request_in -> only 5 valids, busy_out=0 next cycle. A later start restarts at index 0.
- Base build: start_in during STREAM at word 3 -> drop_out one pulse, stream continues unchanged to word 15.
- DOUBLE_BUFFER_EN: block A streaming, start with block B at word 7, second start at word 9 -> only the second start drops. Word 15 of A is followed by word 0 of B on the next request with no gap.
- Reset asserted mid-stream at word 8 -> next cycle all outputs 0 and state IDLE. Subsequent requests give no valid until a new start.
